// File: rtl/screen_to_float_map.sv
// screen_to_float_map
// Maps an unsigned screen coordinate (nominal 0..360) onto an IEEE-754
// single in [-1.0, +1.0] as (x - 180) / 180. The quotient is formed as
// |x - 180| * K with K = round(2^22 / 180). A normalizer then shifts the
// result one bit per cycle until the hidden bit reaches m[23].
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          synchronous, active-high reset
//   valid_in        input_integer is valid this cycle
//   input_integer   [31:0] screen coordinate, clamped to 360
//   ready_out       block can accept a new input this cycle
//   data_valid_out  one-cycle pulse; output_float newly valid
//   output_float    [31:0] IEEE-754 single result, held between results
//
// Optional feature:
//   SCREEN_MAP_INVERT_EN  flips the screen axis so that d = 180 - x.
//                         x = 0 maps to +1.0 and x = 360 maps to -1.0.

module screen_to_float_map (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] input_integer,
  output logic        ready_out,
  output logic        data_valid_out,
  output logic [31:0] output_float
);

  localparam int unsigned XW     = 9;
  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 10;
  localparam int unsigned MW     = 24;
  localparam int unsigned EW     = 8;
  localparam int unsigned X_MAX  = 360;
  localparam int unsigned CENTRE = 180;
  localparam int unsigned K      = 23302;
  localparam int unsigned EXP0   = 128;

  localparam logic [31:0] POS_ONE = 32'h3F80_0000;
  localparam logic [31:0] NEG_ONE = 32'hBF80_0000;

  typedef enum logic [1:0] {IDLE, CALC, NORM, PACK} state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [MW-1:0]   m;
  logic [EW-1:0]   exp_r;
  logic            sign;
  logic            is_zero;
  logic            is_one;

  logic [XW-1:0]        x_clamp;
  logic signed [DW-1:0] d;
  logic [AW-1:0]        a;
  logic [MW-1:0]        prod;

  // Input clamp plus the signed offset from centre and its magnitude.
  always_comb begin
    x_clamp = (input_integer > 32'(X_MAX)) ? XW'(X_MAX) : input_integer[XW-1:0];
`ifdef SCREEN_MAP_INVERT_EN
    d = DW'(CENTRE) - $signed({1'b0, x});
`else
    d = $signed({1'b0, x}) - DW'(CENTRE);
`endif
    a    = d[DW-1] ? AW'(-d) : AW'(d);
    prod = MW'(a) * MW'(K);
  end

  // Control and datapath: accept, scale, normalize, then pack.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      ready_out      <= 1'b0;
      data_valid_out <= 1'b0;
      output_float   <= 32'h0;
      x              <= '0;
      m              <= '0;
      exp_r          <= '0;
      sign           <= 1'b0;
      is_zero        <= 1'b0;
      is_one         <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (valid_in && ready_out) begin
            x         <= x_clamp;
            ready_out <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          sign    <= d[DW-1];
          m       <= prod;
          exp_r   <= EW'(EXP0);
          is_zero <= (a == '0);
          is_one  <= (a == AW'(CENTRE));
          state   <= NORM;
        end
        NORM: begin
          // Left shifts only, so truncation is exact; no rounding is needed.
          if (is_zero || is_one || m[MW-1]) begin
            state <= PACK;
          end else begin
            m     <= {m[MW-2:0], 1'b0};
            exp_r <= exp_r - EW'(1);
          end
        end
        PACK: begin
          if (is_zero) begin
            output_float <= 32'h0;
          end else if (is_one) begin
            output_float <= sign ? NEG_ONE : POS_ONE;
          end else begin
            output_float <= {sign, exp_r, m[MW-2:0]};
          end
          data_valid_out <= 1'b1;
          ready_out      <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          ready_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screen_to_float_map.sv
// Testbench for screen_to_float_map. Stimulus is directed corner cases
// followed by random coordinates. Each result is compared against a
// real-arithmetic model of (x - 180) / 180. Latency, pulse width, the hold
// of the output, back-to-back throughput and reset abort are checked too.

module tb_screen_to_float_map;

`ifdef SCREEN_MAP_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] input_integer;
  logic        ready_out;
  logic        data_valid_out;
  logic [31:0] output_float;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  screen_to_float_map dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .input_integer  (input_integer),
    .ready_out      (ready_out),
    .data_valid_out (data_valid_out),
    .output_float   (output_float)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Exactly representable doubles are narrowed to single-precision bits.
  function automatic logic [31:0] real_to_single(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
  endfunction

  // Reference: value = (x - 180) / 180, with the scale K = round(2^22/180).
  // Latency is 3 plus the shift count needed to bring the product to 24 bits.
  task automatic model(input logic [31:0] xin, output logic [31:0] val, output int lat);
    int  xc, d, a, m;
    real sgn;
    xc  = (xin > 32'd360) ? 360 : int'(xin);
    d   = INV ? (180 - xc) : (xc - 180);
    a   = (d < 0) ? -d : d;
    sgn = (d < 0) ? -1.0 : 1.0;
    if (a == 0) begin
      val = 32'h0;
      lat = 3;
    end else if (a == 180) begin
      val = real_to_single(sgn);
      lat = 3;
    end else begin
      m   = a * 23302;
      val = real_to_single(sgn * real'(m) / 4194304.0);
      lat = 3 + 24 - $clog2(m + 1);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] xin);
    logic [31:0] exp_val, hold;
    int          exp_lat, cyc;
    bit          ready_bad, hold_bad;
    model(xin, exp_val, exp_lat);
    cyc = 0;
    while (!ready_out && cyc < 50) begin
      step();
      cyc++;
    end
    check({tag, " ready_before"}, 32'(ready_out), 32'd1);
    hold          = output_float;
    valid_in      = 1'b1;
    input_integer = xin;
    step();
    cyc       = 0;
    ready_bad = 1'b0;
    hold_bad  = 1'b0;
    while (!data_valid_out && cyc < 40) begin
      if (ready_out) ready_bad = 1'b1;
      if (output_float !== hold) hold_bad = 1'b1;
      // Junk offered while busy must be ignored.
      valid_in      = 1'($urandom_range(0, 1));
      input_integer = $urandom;
      step();
      cyc++;
    end
    valid_in = 1'b0;
    check({tag, " dv_seen"}, 32'(data_valid_out), 32'd1);
    check({tag, " value"}, output_float, exp_val);
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " ready_low_busy"}, 32'(ready_bad), 32'd0);
    check({tag, " hold"}, 32'(hold_bad), 32'd0);
    check({tag, " ready_with_dv"}, 32'(ready_out), 32'd1);
    hold = output_float;
    step();
    check({tag, " dv_one_cycle"}, 32'(data_valid_out), 32'd0);
    check({tag, " hold_after"}, output_float, hold);
  endtask

  initial begin
    logic [31:0] exp_val;
    int          exp_lat, cyc, last, n;
    bit          seen;
    logic [31:0] dir [12] = '{32'd180, 32'd360, 32'd0, 32'd500, 32'd270, 32'd181,
                              32'd179, 32'd1, 32'd359, 32'd90, 32'hFFFF_FFFF, 32'd361};

    rst_in        = 1'b1;
    valid_in      = 1'b0;
    input_integer = 32'h0;
    step();
    step();
    check("reset ready", 32'(ready_out), 32'd0);
    check("reset dv", 32'(data_valid_out), 32'd0);
    check("reset out", output_float, 32'h0);
    rst_in = 1'b0;
    step();
    check("post reset ready", 32'(ready_out), 32'd1);

    foreach (dir[i]) run_one($sformatf("dir x=%0d", dir[i]), dir[i]);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] xr;
      xr = (i % 5 == 4) ? $urandom : 32'($urandom_range(0, 360));
      run_one($sformatf("rnd x=%0d", xr), xr);
    end

    // Continuous valid_in: results spaced by the full 6-cycle turn-around.
    model(32'd270, exp_val, exp_lat);
    valid_in      = 1'b1;
    input_integer = 32'd270;
    cyc  = 0;
    last = 0;
    n    = 0;
    while (n < 3 && cyc < 60) begin
      step();
      cyc++;
      if (data_valid_out) begin
        check($sformatf("b2b value %0d", n), output_float, exp_val);
        if (n > 0) check($sformatf("b2b gap %0d", n), 32'(cyc - last), 32'(exp_lat + 1));
        last = cyc;
        n++;
      end
    end
    valid_in = 1'b0;
    check("b2b count", 32'(n), 32'd3);
    step();

    // Reset during normalization aborts without a result pulse.
    run_one("pre_reset x=270", 32'd270);
    valid_in      = 1'b1;
    input_integer = 32'd181;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    rst_in = 1'b1;
    step();
    check("abort dv", 32'(data_valid_out), 32'd0);
    check("abort out", output_float, 32'h0);
    check("abort ready", 32'(ready_out), 32'd0);
    rst_in = 1'b0;
    step();
    check("abort ready next", 32'(ready_out), 32'd1);
    seen = 1'b0;
    repeat (15) begin
      if (data_valid_out) seen = 1'b1;
      step();
    end
    check("abort no dv", 32'(seen), 32'd0);
    check("abort out held", output_float, 32'h0);
    run_one("post_reset x=90", 32'd90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
